// File: rtl/io_in_pad_sync.sv
// Multi-channel input pad: per-channel flop synchroniser, debounce filter, fan-out and edge pulses.
// Optional per-channel aborted-change counters are enabled with the IOPAD_GLITCH_CNT_EN macro.
module io_in_pad_sync #(
  parameter int   WIDTH       = 1,
  parameter int   FANOUT      = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   DEBOUNCE    = 4,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef IOPAD_GLITCH_CNT_EN
  input  logic                      glitch_clr,
  output logic [WIDTH*8-1:0]        glitch_cnt,
`endif
  input  logic [WIDTH-1:0]          top_pin,
  output logic [WIDTH*FANOUT-1:0]   pins,
  output logic [WIDTH-1:0]          level,
  output logic [WIDTH-1:0]          rise,
  output logic [WIDTH-1:0]          fall
);

  localparam int               CNT_W    = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  sync_out;
  logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]                  level_q, level_d;
  logic [WIDTH-1:0]                  rise_q, rise_d;
  logic [WIDTH-1:0]                  fall_q, fall_d;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], top_pin};
  assign sync_out = sync_q[SYNC_STAGES-1];

  // The level only moves after DEBOUNCE consecutive disagreeing samples; any agreement restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    for (int c = 0; c < WIDTH; c++) begin
      if (sync_out[c] == level_q[c]) begin
        cnt_d[c] = '0;
      end else if (cnt_q[c] == CNT_LAST) begin
        level_d[c] = sync_out[c];
        cnt_d[c]   = '0;
      end else begin
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
      end
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= {(SYNC_STAGES*WIDTH){RESET_VAL}};
      cnt_q   <= '0;
      level_q <= {WIDTH{RESET_VAL}};
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign pins  = {FANOUT{level_q}};
  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

`ifdef IOPAD_GLITCH_CNT_EN
  logic [WIDTH-1:0][7:0] gcnt_q, gcnt_d;

  // An aborted change is a partial count that is cancelled by the input returning to the level.
  always_comb begin
    gcnt_d = gcnt_q;
    if (glitch_clr) begin
      gcnt_d = '0;
    end else begin
      for (int c = 0; c < WIDTH; c++) begin
        if ((cnt_q[c] != '0) && (sync_out[c] == level_q[c]) && (gcnt_q[c] != 8'hff)) begin
          gcnt_d[c] = gcnt_q[c] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gcnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
    end
  end

  assign glitch_cnt = gcnt_q;
`endif

endmodule

// File: doc/io_in_pad_sync.md
Name: io_in_pad_sync

Overview:
Parametrised multi-channel input pad block and successor to the single-bit fan-out input pad.
- Samples WIDTH asynchronous top-level pins.
- Passes each through a SYNC_STAGES flop synchroniser, then a per-channel debounce filter.
- Drives the filtered level to FANOUT copies per channel, plus registered rise/fall pulses.
- Sits between the top-level pad ring and fabric logic that needs clean, synchronous inputs.

Parameters:
WIDTH, 1, number of input channels (>=1)
FANOUT, 4, copies of each filtered channel on pins (>=1)
SYNC_STAGES, 2, synchroniser depth (>=2)
DEBOUNCE, 4, consecutive stable synchronised cycles required before level changes (>=1; 1 = no filtering)
RESET_VAL, 0, 1-bit value loaded into every synchroniser, level and history flop at reset

Ports:
clk  input  1  single clock, posedge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
top_pin  input  WIDTH  raw asynchronous pad inputs
pins  output  WIDTH*FANOUT  filtered levels; copy k of channel c at bit k*WIDTH+c
level  output  WIDTH  filtered level per channel
rise  output  WIDTH  one-cycle pulse when level goes 0->1
fall  output  WIDTH  one-cycle pulse when level goes 1->0

Behaviour:
- Reset (rst low, asynchronous):
  - all synchroniser stages and level = RESET_VAL per channel
  - debounce counters = 0; rise = fall = 0
  - pins = RESET_VAL replicated
  - reset release is synchronous to clk only through normal flop behaviour; no extra reset synchroniser inside.
- Synchroniser: per-channel shift chain of SYNC_STAGES flops; sync_out = last stage. No logic between stages.
- Debounce counter, per channel:
  - width clog2(DEBOUNCE+1); counts consecutive cycles where sync_out != level.
  - sync_out == level: counter <= 0.
  - Mismatch and counter < DEBOUNCE-1: counter increments.
  - Mismatch and counter == DEBOUNCE-1: level <= sync_out and counter <= 0.
- Latency: let top_pin change before edge E1 and hold stable. Level changes on edge E(SYNC_STAGES+DEBOUNCE). Defaults: 6th edge.
- Glitch rejection: any return of sync_out to level before the count completes zeroes the counter; level does not change.
- Edge pulses:
  - rise/fall are registered and update on the same edge as level.
  - rise = 1 for exactly one cycle after level changes 0->1; fall likewise for 1->0.
  - rise and fall are never both high on the same channel.
- pins is pure combinational replication of level; no additional latency.
- Channels are fully independent; simultaneous changes on several channels each follow the rules above.
- Reset mid-debounce: the counter is discarded. If top_pin differs from RESET_VAL after release, the full latency restarts from the first post-release edge and a pulse is emitted on the transition.
- A post-reset input equal to RESET_VAL produces no pulse.

Optional Feature:
Macro IOPAD_GLITCH_CNT_EN.
- Defined:
  - adds input glitch_clr (1 bit, synchronous, active-high) and output glitch_cnt (WIDTH*8; channel c at bits [8c+7:8c]).
  - Each channel's 8-bit counter increments when its debounce counter is nonzero and sync_out returns to level (an aborted change). It saturates at 255.
  - Counters reset to 0 on rst.
  - glitch_clr zeroes all counters. It takes priority over a same-cycle increment.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, defaults, top_pin=0 -> level=0, pins=4'b0000, rise=fall=0. Release reset: no pulses.
- Defaults, top_pin 0->1 held -> level=1 and rise=1 on 6th edge, rise=0 on 7th, pins=4'b1111.
- Defaults, top_pin high for 3 sync'd cycles then low -> level stays 0, no rise. With IOPAD_GLITCH_CNT_EN, glitch_cnt=1.
- WIDTH=3, FANOUT=2, top_pin 3'b000->3'b101 -> level=3'b101, rise=3'b101 same cycle, pins=6'b101101.
- Defaults, top_pin=1 held, rst pulsed low at edge 4 of debounce -> level=0 during reset. After release, level=1 with rise exactly 6 edges later.
- DEBOUNCE=1, SYNC_STAGES=3, top_pin 1->0 with RESET_VAL=1 -> fall=1 and level=0 on 4th edge.
